// File: rtl/simplify_formula.sv
// Unit propagation step for a small CNF formula: applies one assigned literal
// to every clause, one clause per cycle, and reports conflict or satisfaction.
package common;
    localparam int NC    = 4;
    localparam int NL    = 3;
    localparam int NUM_W = 8;
    localparam int LEN_W = $clog2(NL + 1);

    typedef struct packed {
        logic [NUM_W-1:0] num;
        logic             val;
    } lit;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        lit [NL-1:0]      lits;
    } clause;

    typedef clause [NC-1:0] formula;

    localparam formula zero_formula = '0;
endpackage

module simplify_formula
    import common::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   start,
    input  formula formula_in,
    input  lit     lit_in,
    output formula formula_out,
    output logic   busy,
    output logic   done,
    output logic   conflict,
    output logic   sat
);
    localparam int IDX_W  = $clog2(NC + 1);
    localparam int SLOT_W = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    formula             formula_q, formula_d;
    lit                 lit_q, lit_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               conflict_q, conflict_d;
    logic               sat_q, sat_d;

    logic [SLOT_W-1:0]  slot;
    clause              reduced;
    logic               emptied;
    logic               all_empty;

    // Only slots below len take part; a clause left without removals is untouched.
    function automatic clause reduce_clause(input clause c, input lit l, output logic empty_out);
        logic             hit;
        logic             any_rm;
        logic [LEN_W-1:0] cnt;
        clause            r;
        hit       = 1'b0;
        any_rm    = 1'b0;
        cnt       = '0;
        r         = c;
        empty_out = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if (k < int'(c.len) && c.lits[k].num == l.num) begin
                if (c.lits[k].val == l.val) hit = 1'b1;
                else any_rm = 1'b1;
            end
        end
        if (hit) begin
            r.len = '0;
        end else if (any_rm) begin
            for (int k = 0; k < NL; k++) begin
                if (k < int'(c.len) && c.lits[k].num != l.num) begin
                    r.lits[cnt] = c.lits[k];
                    cnt = cnt + LEN_W'(1);
                end
            end
            for (int k = 0; k < NL; k++) begin
                if (k >= int'(cnt) && k < int'(c.len)) r.lits[k] = '0;
            end
            r.len     = cnt;
            empty_out = (cnt == '0);
        end
        return r;
    endfunction

    assign slot = idx_q[SLOT_W-1:0];

    always_comb begin
        emptied   = 1'b0;
        reduced   = reduce_clause(formula_q[slot], lit_q, emptied);
        all_empty = 1'b1;
        for (int i = 0; i < NC; i++) begin
            if (formula_q[i].len != '0) all_empty = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        formula_d  = formula_q;
        lit_d      = lit_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        conflict_d = conflict_q;
        sat_d      = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    formula_d  = formula_in;
                    lit_d      = lit_in;
                    idx_d      = '0;
                    conflict_d = 1'b0;
                    sat_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Stop one edge after the last clause or after the clause that emptied.
                if (conflict_q || idx_q == IDX_W'(NC)) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    sat_d   = all_empty && !conflict_q;
                end else begin
                    formula_d[slot] = reduced;
                    if (emptied) conflict_d = 1'b1;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            formula_q  <= zero_formula;
            lit_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            formula_q  <= formula_d;
            lit_q      <= lit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
            sat_q      <= sat_d;
        end
    end

    assign formula_out = formula_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign conflict    = conflict_q;
    assign sat         = sat_q;
endmodule

// File: tb/tb_simplify_formula.sv
// Directed bench for simplify_formula: hand-built formulas with hand-derived results.
module tb_simplify_formula;
    import common::*;

    logic   clock;
    logic   reset;
    logic   start;
    formula formula_in;
    lit     lit_in;
    formula formula_out;
    logic   busy;
    logic   done;
    logic   conflict;
    logic   sat;

    int vectors;
    int miscompares;

    simplify_formula dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .formula_in  (formula_in),
        .lit_in      (lit_in),
        .formula_out (formula_out),
        .busy        (busy),
        .done        (done),
        .conflict    (conflict),
        .sat         (sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic lit mk_lit(input int n, input bit v);
        lit x;
        x.num = NUM_W'(n);
        x.val = v;
        return x;
    endfunction

    function automatic clause mk_cl(input int len, input lit a, input lit b, input lit c);
        clause x;
        x.len     = LEN_W'(len);
        x.lits[0] = a;
        x.lits[1] = b;
        x.lits[2] = c;
        return x;
    endfunction

    // Accept on the next edge, then count edges until done is seen (-1 on timeout).
    task automatic apply(input formula f, input lit l, output int lat);
        start      = 1'b1;
        formula_in = f;
        lit_in     = l;
        @(posedge clock); #1;
        start = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    lit z;
    formula fa, ea, fb, eb;
    lit la, lb;

    task automatic build_common;
        z = mk_lit(0, 0);
        fa[0] = mk_cl(2, mk_lit(1, 1), mk_lit(2, 0), z);
        fa[1] = mk_cl(2, mk_lit(1, 0), mk_lit(3, 1), z);
        fa[2] = mk_cl(1, mk_lit(2, 1), z, z);
        fa[3] = mk_cl(0, z, z, z);
        la    = mk_lit(1, 1);
        ea[0] = mk_cl(0, mk_lit(1, 1), mk_lit(2, 0), z);
        ea[1] = mk_cl(1, mk_lit(3, 1), z, z);
        ea[2] = mk_cl(1, mk_lit(2, 1), z, z);
        ea[3] = mk_cl(0, z, z, z);
        fb[0] = mk_cl(1, mk_lit(5, 0), z, z);
        fb[1] = mk_cl(2, mk_lit(5, 1), mk_lit(6, 1), z);
        fb[2] = mk_cl(0, z, z, z);
        fb[3] = mk_cl(0, z, z, z);
        lb    = mk_lit(5, 1);
        eb[0] = mk_cl(0, z, z, z);
        eb[1] = mk_cl(2, mk_lit(5, 1), mk_lit(6, 1), z);
        eb[2] = mk_cl(0, z, z, z);
        eb[3] = mk_cl(0, z, z, z);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        vectors++;
        if ({busy, done, conflict, sat} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, conflict, sat});
        end
        vectors++;
        if (formula_out !== zero_formula) begin
            miscompares++;
            $display("FAIL reset_formula: got %h expected %h", formula_out, zero_formula);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic;
        int lat;
        apply(fa, la, lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d expected 5", lat);
        end
        vectors++;
        if (formula_out !== ea) begin
            miscompares++;
            $display("FAIL basic_formula: got %h expected %h", formula_out, ea);
        end
        vectors++;
        if ({conflict, sat, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL basic_flags: got %b expected 001", {conflict, sat, busy});
        end
        @(posedge clock); #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got %b expected 00", {done, busy});
        end
    endtask

    task automatic test_conflict;
        int lat;
        apply(fb, lb, lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL conflict_latency: got %0d expected 2", lat);
        end
        vectors++;
        if (formula_out !== eb) begin
            miscompares++;
            $display("FAIL conflict_formula: got %h expected %h", formula_out, eb);
        end
        vectors++;
        if ({conflict, sat} !== 2'b10) begin
            miscompares++;
            $display("FAIL conflict_flags: got %b expected 10", {conflict, sat});
        end
        @(posedge clock); #1;
        vectors++;
        if (conflict !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_held: got %b expected 1", conflict);
        end
    endtask

    task automatic test_sat;
        formula f, e;
        int lat;
        f[0] = mk_cl(1, mk_lit(7, 1), z, z);
        f[1] = mk_cl(2, mk_lit(1, 0), mk_lit(7, 1), z);
        f[2] = mk_cl(3, mk_lit(2, 1), mk_lit(3, 0), mk_lit(7, 1));
        f[3] = mk_cl(2, mk_lit(7, 1), mk_lit(7, 1), z);
        e = f;
        for (int i = 0; i < NC; i++) e[i].len = '0;
        apply(f, mk_lit(7, 1), lat);
        vectors++;
        if (lat !== NC + 1) begin
            miscompares++;
            $display("FAIL sat_latency: got %0d expected %0d", lat, NC + 1);
        end
        vectors++;
        if (formula_out !== e) begin
            miscompares++;
            $display("FAIL sat_formula: got %h expected %h", formula_out, e);
        end
        vectors++;
        if ({sat, conflict} !== 2'b10) begin
            miscompares++;
            $display("FAIL sat_flags: got %b expected 10", {sat, conflict});
        end
        @(posedge clock); #1;
    endtask

    task automatic test_compact;
        formula f, e;
        int lat;
        f    = zero_formula;
        f[0] = mk_cl(3, mk_lit(4, 0), mk_lit(2, 1), mk_lit(4, 0));
        e    = zero_formula;
        e[0] = mk_cl(1, mk_lit(2, 1), z, z);
        apply(f, mk_lit(4, 1), lat);
        vectors++;
        if (formula_out !== e) begin
            miscompares++;
            $display("FAIL compact_formula: got %h expected %h", formula_out, e);
        end
        vectors++;
        if ({conflict, sat, lat[3:0]} !== {2'b00, 4'd5}) begin
            miscompares++;
            $display("FAIL compact_flags: got c=%b s=%b lat=%0d expected c=0 s=0 lat=5", conflict, sat, lat);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_inactive_slots;
        formula f;
        int lat;
        f    = zero_formula;
        f[0] = mk_cl(1, mk_lit(2, 1), mk_lit(9, 1), z);
        f[1] = mk_cl(1, mk_lit(3, 0), mk_lit(9, 0), z);
        apply(f, mk_lit(9, 1), lat);
        vectors++;
        if (formula_out !== f) begin
            miscompares++;
            $display("FAIL inactive_formula: got %h expected %h", formula_out, f);
        end
        vectors++;
        if ({conflict, sat} !== 2'b00) begin
            miscompares++;
            $display("FAIL inactive_flags: got %b expected 00", {conflict, sat});
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back;
        int dones_a;
        int first_done;
        start      = 1'b1;
        formula_in = fa;
        lit_in     = la;
        @(posedge clock); #1;
        dones_a    = 0;
        first_done = -1;
        for (int e = 1; e <= 12; e++) begin
            start = (e == 2 || e == 5 || e == 6 || e == 7);
            if (e >= 6) begin
                formula_in = fb;
                lit_in     = lb;
            end
            @(posedge clock); #1;
            if (e == 3) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_busy: got %b expected 1", busy);
                end
            end
            if (done) begin
                if (first_done < 0) first_done = e;
                if (e <= 8) dones_a++;
            end
            if (e == 6) begin
                vectors++;
                if (formula_out !== ea) begin
                    miscompares++;
                    $display("FAIL b2b_ignored_start: got %h expected %h", formula_out, ea);
                end
            end
            if (e == 9) begin
                vectors++;
                if ({done, conflict, formula_out} !== {2'b11, eb}) begin
                    miscompares++;
                    $display("FAIL b2b_second_run: got d=%b c=%b f=%h expected d=1 c=1 f=%h",
                             done, conflict, formula_out, eb);
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (first_done !== 5) begin
            miscompares++;
            $display("FAIL b2b_first_done: got %0d expected 5", first_done);
        end
        vectors++;
        if (dones_a !== 1) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d expected 1", dones_a);
        end
    endtask

    task automatic test_mid_reset;
        int dones;
        int lat;
        start      = 1'b1;
        formula_in = fb;
        lit_in     = lb;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if ({busy, conflict} !== 2'b11) begin
            miscompares++;
            $display("FAIL midrst_before: got %b expected 11", {busy, conflict});
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({busy, done, conflict, sat} !== 4'b0000 || formula_out !== zero_formula) begin
            miscompares++;
            $display("FAIL midrst_async: got flags=%b f=%h expected flags=0000 f=0",
                     {busy, done, conflict, sat}, formula_out);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (done) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL midrst_no_done: got %0d expected 0", dones);
        end
        apply(fa, la, lat);
        vectors++;
        if (lat !== 5 || formula_out !== ea || {conflict, sat} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_rerun: got lat=%0d f=%h c=%b s=%b expected lat=5 f=%h c=0 s=0",
                     lat, formula_out, conflict, sat, ea);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        formula_in  = zero_formula;
        lit_in      = '0;
        reset       = 1'b1;
        build_common();
        test_reset();
        test_basic();
        test_conflict();
        test_sat();
        test_compact();
        test_inactive_slots();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
